// File: rtl/cache_rd_arbiter.sv
// Two-port read arbiter (icache I, dcache D) in front of the single AXI bridge read port.
// Optional round-robin grant via `RD_ARB_RR_EN; default build is fixed priority D > I.
module cache_rd_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BEATS = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              i_rd_req,
  input  logic [2:0]        i_rd_type,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic              i_ret_last,
  output logic [DATA_W-1:0] i_ret_data,
  input  logic              d_rd_req,
  input  logic [2:0]        d_rd_type,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic              d_ret_last,
  output logic [DATA_W-1:0] d_ret_data,
  output logic              bus_rd_req,
  output logic [2:0]        bus_rd_type,
  output logic [ADDR_W-1:0] bus_rd_addr,
  input  logic              bus_rd_rdy,
  input  logic              bus_ret_valid,
  input  logic              bus_ret_last,
  input  logic [DATA_W-1:0] bus_ret_data,
  input  logic              err_clr,
  output logic              arb_err,
  output logic [1:0]        dbg_state
);

  // Handshakes: a request transfers when req & rdy are high in the same cycle;
  // bus request transfers on bus_rd_req & bus_rd_rdy; each bus_ret_valid cycle is one beat.

  localparam int CNT_W = $clog2(LINE_BEATS) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic               grant_i;
  logic               grant_d;
  logic               accept;
  logic               in_resp;
  logic               beat;
  logic               err_set;
  logic               owner;       // 1 = D owns the outstanding transaction
  logic [2:0]         lat_type;
  logic [ADDR_W-1:0]  lat_addr;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   exp_last;

`ifdef RD_ARB_RR_EN
  logic last_grant;  // 1 = D was granted most recently

  always_comb begin
    grant_d = d_rd_req & (~i_rd_req | ~last_grant);
    grant_i = i_rd_req & (~d_rd_req | last_grant);
  end

  always_ff @(posedge aclk) begin
    if (areset)      last_grant <= 1'b0;
    else if (accept) last_grant <= grant_d;
  end
`else
  always_comb begin
    grant_d = d_rd_req;
    grant_i = i_rd_req & ~d_rd_req;
  end
`endif

  assign i_rd_rdy = (state == S_IDLE) & ~areset & grant_i;
  assign d_rd_rdy = (state == S_IDLE) & ~areset & grant_d;
  assign accept   = (i_rd_req & i_rd_rdy) | (d_rd_req & d_rd_rdy);
  assign in_resp  = (state == S_RESP);
  assign beat     = in_resp & bus_ret_valid;
  assign exp_last = (lat_type == 3'b100) ? CNT_W'(LINE_BEATS - 1) : '0;

  // Early last, missing last, and any beat outside RESP are all protocol errors.
  assign err_set = (bus_ret_valid & ~in_resp)
                 | (beat &  bus_ret_last & (beat_cnt != exp_last))
                 | (beat & ~bus_ret_last & (beat_cnt == exp_last));

  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept)                        state_nxt = S_REQ;
      S_REQ:   if (bus_rd_rdy)                    state_nxt = S_RESP;
      S_RESP:  if (bus_ret_valid & bus_ret_last)  state_nxt = S_IDLE;
      default:                                    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      owner    <= 1'b0;
      lat_type <= '0;
      lat_addr <= '0;
      beat_cnt <= '0;
      arb_err  <= 1'b0;
    end else begin
      if (accept) begin
        owner    <= grant_d;
        lat_type <= grant_d ? d_rd_type : i_rd_type;
        lat_addr <= grant_d ? d_rd_addr : i_rd_addr;
      end
      // Counter saturates so a runaway return after a missing last cannot wrap.
      if (bus_rd_req & bus_rd_rdy)
        beat_cnt <= '0;
      else if (beat && beat_cnt != {CNT_W{1'b1}})
        beat_cnt <= beat_cnt + 1'b1;
      if (err_set)      arb_err <= 1'b1;
      else if (err_clr) arb_err <= 1'b0;
    end
  end

  always_comb begin
    bus_rd_req  = (state == S_REQ);
    bus_rd_type = lat_type;
    bus_rd_addr = lat_addr;
    i_ret_valid = beat & ~owner;
    i_ret_last  = beat & ~owner & bus_ret_last;
    d_ret_valid = beat & owner;
    d_ret_last  = beat & owner & bus_ret_last;
    i_ret_data  = in_resp ? bus_ret_data : '0;
    d_ret_data  = in_resp ? bus_ret_data : '0;
    dbg_state   = state;
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Randomized bench for cache_rd_arbiter: transaction-level model of grant order, beat routing
// and the sticky error flag; build with +define+RD_ARB_RR_EN for round-robin.
module tb_cache_rd_arbiter;

`ifdef RD_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        aclk;
  logic        areset;
  logic        i_rd_req, d_rd_req;
  logic [2:0]  i_rd_type, d_rd_type;
  logic [31:0] i_rd_addr, d_rd_addr;
  logic        i_rd_rdy, d_rd_rdy;
  logic        i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
  logic [31:0] i_ret_data, d_ret_data;
  logic        bus_rd_req;
  logic [2:0]  bus_rd_type;
  logic [31:0] bus_rd_addr;
  logic        bus_rd_rdy, bus_ret_valid, bus_ret_last;
  logic [31:0] bus_ret_data;
  logic        err_clr, arb_err;
  logic [1:0]  dbg_state;

  cache_rd_arbiter dut (
    .aclk(aclk), .areset(areset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .bus_rd_req(bus_rd_req), .bus_rd_type(bus_rd_type), .bus_rd_addr(bus_rd_addr),
    .bus_rd_rdy(bus_rd_rdy), .bus_ret_valid(bus_ret_valid), .bus_ret_last(bus_ret_last),
    .bus_ret_data(bus_ret_data), .err_clr(err_clr), .arb_err(arb_err), .dbg_state(dbg_state)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: who won last, and whether the sticky error should be set
  bit m_last_d;
  bit m_err;
  logic [33:0] exp_q[$];  // {owner_is_d, last, data}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic to_neg();
    @(negedge aclk);
  endtask

  task automatic idle_inputs();
    i_rd_req = 0; d_rd_req = 0; bus_rd_rdy = 0; bus_ret_valid = 0; bus_ret_last = 0;
    bus_ret_data = '0; err_clr = 0;
  endtask

  task automatic clear_err();
    err_clr = 1;
    tick();
    err_clr = 0;
    m_err = 0;
    to_neg();
    check("err_cleared", arb_err, 0);
    tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_bus"}, {bus_rd_req, bus_rd_type, bus_rd_addr}, 0);
    check({tag, "_ctl"}, {i_rd_rdy, d_rd_rdy, i_ret_valid, i_ret_last, d_ret_valid, d_ret_last, arb_err}, 0);
    check({tag, "_data"}, {i_ret_data, d_ret_data}, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // One full transaction. last_at=0 means a well-formed return; abort_at=k returns just before beat k.
  task automatic run_txn(input bit i_on, input bit d_on, input logic [2:0] it, input logic [2:0] dt,
                         input logic [31:0] ia, input logic [31:0] da, input int rdy_dly,
                         input int last_at, input bit gaps, input bit stray_req,
                         input logic [31:0] base, input int abort_at);
    bit          win_d;
    logic [2:0]  wt;
    logic [31:0] wa;
    int          exp_n;
    int          n;
    logic [33:0] e;
    logic [31:0] dat;
    win_d = (i_on && d_on) ? (RR ? !m_last_d : 1'b1) : d_on;
    wt = win_d ? dt : it;
    wa = win_d ? da : ia;
    i_rd_req = i_on; d_rd_req = d_on;
    i_rd_type = it; d_rd_type = dt; i_rd_addr = ia; d_rd_addr = da;
    to_neg();
    check("i_rd_rdy", i_rd_rdy, !win_d);
    check("d_rd_rdy", d_rd_rdy, win_d);
    check("bus_req_idle", bus_rd_req, 0);
    tick();
    m_last_d = win_d;
    if (win_d) d_rd_req = 0; else i_rd_req = 0;
    for (int c = 0; c <= rdy_dly; c++) begin
      bus_rd_rdy = (c == rdy_dly);
      bus_ret_valid = stray_req && (c == 0);
      bus_ret_data = 32'hDEAD;
      to_neg();
      check("bus_rd_req", bus_rd_req, 1);
      check("bus_rd_type", bus_rd_type, wt);
      check("bus_rd_addr", bus_rd_addr, wa);
      check("rdy_busy", {i_rd_rdy, d_rd_rdy}, 0);
      check("no_ret_in_req", {i_ret_valid, d_ret_valid}, 0);
      tick();
    end
    if (stray_req) m_err = 1;
    bus_rd_rdy = 0; bus_ret_valid = 0;
    exp_n = (wt == 3'b100) ? 4 : 1;
    n = (last_at > 0) ? last_at : exp_n;
    for (int k = 1; k <= n; k++) begin
      if (k == abort_at) return;
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus_ret_valid = 0;
          to_neg();
          check("gap_no_valid", {i_ret_valid, d_ret_valid, bus_rd_req}, 0);
          tick();
        end
      end
      dat = (base != 0) ? base + 32'(k - 1) : $urandom;
      exp_q.push_back({win_d, (k == n), dat});
      bus_ret_valid = 1; bus_ret_last = (k == n); bus_ret_data = dat;
      to_neg();
      e = exp_q.pop_front();
      check("owner_valid", win_d ? d_ret_valid : i_ret_valid, 1);
      check("owner_last", win_d ? d_ret_last : i_ret_last, e[32]);
      check("owner_data", win_d ? d_ret_data : i_ret_data, e[31:0]);
      check("other_valid", win_d ? i_ret_valid : d_ret_valid, 0);
      check("bus_req_resp", bus_rd_req, 0);
      tick();
    end
    bus_ret_valid = 0; bus_ret_last = 0;
    if (n != exp_n) m_err = 1;
    to_neg();
    check("arb_err", arb_err, m_err);
    check("state_idle", dbg_state, 0);
    if (i_on && d_on) check("loser_rdy_next", win_d ? i_rd_rdy : d_rd_rdy, 1);
    i_rd_req = 0; d_rd_req = 0;
    tick();
  endtask

  function automatic logic [2:0] rand_type();
    logic [2:0] tt;
    case ($urandom_range(0, 3))
      0: tt = 3'b000;
      1: tt = 3'b001;
      2: tt = 3'b010;
      default: tt = 3'b100;
    endcase
    return tt;
  endfunction

  initial begin
    idle_inputs();
    i_rd_type = 0; d_rd_type = 0; i_rd_addr = 0; d_rd_addr = 0;
    areset = 1;
    m_last_d = 0; m_err = 0;
    repeat (3) tick();
    areset = 0;
    to_neg();
    check_zero_outputs("reset");
    tick();

    // single I line read, bridge ready on the third request cycle
    run_txn(1, 0, 3'b100, 3'b000, 32'h1C000000, 0, 2, 0, 0, 0, 32'hA0, 0);

    // I and D tie; loser must be granted the cycle after the winner's last
    run_txn(1, 1, 3'b100, 3'b010, 32'h1C000020, 32'h8000, 1, 0, 0, 0, 0, 0);
    run_txn(1, 0, 3'b100, 3'b000, 32'h1C000020, 0, 0, 0, 1, 0, 0, 0);

    // early last on a line read
    run_txn(1, 0, 3'b100, 3'b000, 32'h1C000040, 0, 0, 2, 0, 0, 0, 0);
    clear_err();

    // stray beat in IDLE, then set-beats-clear
    bus_ret_valid = 1; bus_ret_data = 32'hDEAD;
    to_neg();
    check("stray_no_fwd", {i_ret_valid, d_ret_valid}, 0);
    tick();
    err_clr = 1;
    to_neg();
    check("stray_err", arb_err, 1);
    tick();
    bus_ret_valid = 0; err_clr = 0;
    to_neg();
    check("set_wins_clr", arb_err, 1);
    tick();
    clear_err();

    // reset after beat 2 of a line read; residual beat is a stray
    run_txn(1, 0, 3'b100, 3'b000, 32'h1C000080, 0, 0, 0, 0, 0, 0, 3);
    areset = 1;
    tick();
    areset = 0; bus_ret_data = 0;
    m_last_d = 0; m_err = 0;
    to_neg();
    check_zero_outputs("midrst");
    tick();
    bus_ret_valid = 1; bus_ret_data = 32'h55;
    to_neg();
    check("residual_no_fwd", {i_ret_valid, d_ret_valid}, 0);
    tick();
    bus_ret_valid = 0;
    to_neg();
    check("residual_err", arb_err, 1);
    tick();
    clear_err();
    run_txn(1, 0, 3'b100, 3'b000, 32'h1C0000C0, 0, 1, 0, 0, 0, 0, 0);

    // three back-to-back ties from a fresh reset
    areset = 1;
    tick();
    areset = 0; m_last_d = 0; m_err = 0;
    for (int t = 0; t < 3; t++)
      run_txn(1, 1, 3'b010, 3'b010, 32'h100 + 32'(t), 32'h200 + 32'(t), 0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int r = 0; r < 60; r++) begin
      int  mode;
      int  la;
      mode = $urandom_range(1, 3);
      la = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 9) : 0;
      run_txn(mode != 2, mode != 1, rand_type(), rand_type(), $urandom, $urandom,
              $urandom_range(0, 3), la, 1, ($urandom_range(0, 9) == 0), 0, 0);
      if (m_err && $urandom_range(0, 1) == 1) clear_err();
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
